// File: rtl/button_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : button_event_ctrl
// Description : Converts a debounced button level into PRESS / RELEASE /
//               LONG / REPEAT events using a prescaled time base and a
//               three-state FSM. Events leave through a one-entry
//               valid/ready slot with a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module button_event_ctrl #(
    parameter int TICK_DIV     = 200000,
    parameter int PRESC_WIDTH  = 18,
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200,
    parameter int TICK_WIDTH   = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       btn_level,
    input  logic       event_ready,
    input  logic       overflow_clr,
    output logic       event_valid,
    output logic [1:0] event_code,
    output logic       overflow,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_PRESSED = 2'b01,
        S_HELD    = 2'b10
    } state_t;

    localparam logic [1:0] c_ev_press   = 2'b00;
    localparam logic [1:0] c_ev_release = 2'b01;
    localparam logic [1:0] c_ev_long    = 2'b10;
    localparam logic [1:0] c_ev_repeat  = 2'b11;

    localparam logic [PRESC_WIDTH-1:0] c_presc_last  = PRESC_WIDTH'(TICK_DIV - 1);
    localparam logic [TICK_WIDTH-1:0]  c_long_last   = TICK_WIDTH'(LONG_TICKS - 1);
    localparam logic [TICK_WIDTH-1:0]  c_repeat_last = TICK_WIDTH'(REPEAT_TICKS - 1);
    localparam logic                   c_repeat_en   = (REPEAT_TICKS != 0);

    state_t                  r_state;
    logic [PRESC_WIDTH-1:0]  r_presc;
    logic [TICK_WIDTH-1:0]   r_tick_cnt;
    logic                    r_btn_prev;
    logic                    r_valid;
    logic [1:0]              r_code;
    logic                    r_ovf;

    state_t                  w_state_nxt;
    logic [PRESC_WIDTH-1:0]  w_presc_nxt;
    logic [TICK_WIDTH-1:0]   w_tick_nxt;
    logic                    w_gen;
    logic [1:0]              w_gen_code;
    logic                    w_rise;
    logic                    w_fall;
    logic                    w_tick;
    logic                    w_xfer;

    assign w_rise = btn_level & ~r_btn_prev;
    assign w_fall = ~btn_level & r_btn_prev;
    assign w_tick = (r_presc == c_presc_last);
    assign w_xfer = r_valid & event_ready;

    // Edge detector history; tracks the button even while disabled so that a
    // button held across enable re-assertion does not look like a new press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btn_prev <= 1'b0;
        end else begin
            r_btn_prev <= btn_level;
        end
    end

    // Next-state, time-base and event decode; fall beats tick by ordering.
    always_comb begin
        w_state_nxt = r_state;
        w_gen       = 1'b0;
        w_gen_code  = c_ev_press;
        w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
        w_tick_nxt  = r_tick_cnt;

        if (!enable) begin
            w_state_nxt = S_IDLE;
            w_presc_nxt = '0;
            w_tick_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        w_state_nxt = S_PRESSED;
                        w_gen       = 1'b1;
                        w_gen_code  = c_ev_press;
                    end
                end
                S_PRESSED: begin
                    if (w_fall) begin
                        w_state_nxt = S_IDLE;
                        w_gen       = 1'b1;
                        w_gen_code  = c_ev_release;
                    end else if (w_tick) begin
                        if (r_tick_cnt == c_long_last) begin
                            w_state_nxt = S_HELD;
                            w_gen       = 1'b1;
                            w_gen_code  = c_ev_long;
                        end else begin
                            w_tick_nxt = r_tick_cnt + 1'b1;
                        end
                    end
                end
                S_HELD: begin
                    if (w_fall) begin
                        w_state_nxt = S_IDLE;
                        w_gen       = 1'b1;
                        w_gen_code  = c_ev_release;
                    end else if (w_tick) begin
                        if (c_repeat_en && (r_tick_cnt == c_repeat_last)) begin
                            w_gen      = 1'b1;
                            w_gen_code = c_ev_repeat;
                            w_tick_nxt = '0;
                        end else begin
                            w_tick_nxt = r_tick_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase

            // Every state change restarts the time base from zero.
            if (w_state_nxt != r_state) begin
                w_presc_nxt = '0;
                w_tick_nxt  = '0;
            end
        end
    end

    // FSM state, prescaler and tick counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_presc    <= '0;
            r_tick_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_presc    <= w_presc_nxt;
            r_tick_cnt <= w_tick_nxt;
        end
    end

    // One-entry event slot; a new event loads when the slot is empty or is
    // being drained this cycle, otherwise it is dropped and flagged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_code  <= 2'b00;
            r_ovf   <= 1'b0;
        end else begin
            if (overflow_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_gen) begin
                if (!r_valid || w_xfer) begin
                    r_valid <= 1'b1;
                    r_code  <= w_gen_code;
                end else begin
                    r_ovf <= 1'b1;
                end
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign event_valid = r_valid;
    assign event_code  = r_code;
    assign overflow    = r_ovf;
    assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_button_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_event_ctrl
// Description : Self-checking bench for button_event_ctrl: directed vector
//               table, hand-written multi-cycle sequences and a randomized
//               phase compared against a hold-time reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event_ctrl;

    localparam int TICK_DIV     = 4;
    localparam int PRESC_WIDTH  = 3;
    localparam int LONG_TICKS   = 3;
    localparam int REPEAT_TICKS = 2;
    localparam int TICK_WIDTH   = 4;

    // Hold durations in clock cycles measured from PRESS-state entry.
    localparam int LD = LONG_TICKS * TICK_DIV;
    localparam int RD = REPEAT_TICKS * TICK_DIV;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       btn_level;
    logic       event_ready;
    logic       overflow_clr;
    logic       event_valid;
    logic [1:0] event_code;
    logic       overflow;
    logic [1:0] state;

    int n_checks;
    int n_pass;
    bit model_chk;

    button_event_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .PRESC_WIDTH (PRESC_WIDTH),
        .LONG_TICKS  (LONG_TICKS),
        .REPEAT_TICKS(REPEAT_TICKS),
        .TICK_WIDTH  (TICK_WIDTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .btn_level   (btn_level),
        .event_ready (event_ready),
        .overflow_clr(overflow_clr),
        .event_valid (event_valid),
        .event_code  (event_code),
        .overflow    (overflow),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: tracks how long the button has been held since the
    // press was accepted and derives events from that duration.
    // ------------------------------------------------------------------
    bit         m_pressed;
    int         m_age;
    bit         m_prev;
    bit         m_valid;
    logic [1:0] m_code;
    bit         m_ovf;

    always @(posedge clk or posedge reset) begin
        bit         n_pressed;
        int         n_age;
        bit         n_valid;
        logic [1:0] n_code;
        bit         n_ovf;
        bit         gen;
        logic [1:0] g;
        bit         rise;
        bit         fall;
        if (reset) begin
            m_pressed <= 1'b0;
            m_age     <= 0;
            m_prev    <= 1'b0;
            m_valid   <= 1'b0;
            m_code    <= 2'b00;
            m_ovf     <= 1'b0;
        end else begin
            n_pressed = m_pressed;
            n_age     = m_age;
            n_valid   = m_valid;
            n_code    = m_code;
            n_ovf     = m_ovf;
            gen       = 1'b0;
            g         = 2'b00;
            rise      = btn_level && !m_prev;
            fall      = !btn_level && m_prev;
            if (!enable) begin
                n_pressed = 1'b0;
                n_age     = 0;
            end else if (!m_pressed) begin
                if (rise) begin
                    n_pressed = 1'b1;
                    n_age     = 0;
                    gen       = 1'b1;
                    g         = 2'b00;
                end
            end else if (fall) begin
                n_pressed = 1'b0;
                n_age     = 0;
                gen       = 1'b1;
                g         = 2'b01;
            end else begin
                n_age = m_age + 1;
                if (n_age == LD) begin
                    gen = 1'b1;
                    g   = 2'b10;
                end else if (RD != 0 && n_age > LD && ((n_age - LD) % RD) == 0) begin
                    gen = 1'b1;
                    g   = 2'b11;
                end
            end
            if (overflow_clr) n_ovf = 1'b0;
            if (gen) begin
                if (!m_valid || event_ready) begin
                    n_valid = 1'b1;
                    n_code  = g;
                end else begin
                    n_ovf = 1'b1;
                end
            end else if (m_valid && event_ready) begin
                n_valid = 1'b0;
            end
            m_pressed <= n_pressed;
            m_age     <= n_age;
            m_prev    <= btn_level;
            m_valid   <= n_valid;
            m_code    <= n_code;
            m_ovf     <= n_ovf;
        end
    end

    // Model comparison during the randomized phase, away from the clock edge.
    always @(negedge clk) begin
        logic [1:0] es;
        if (model_chk) begin
            es = !m_pressed ? 2'd0 : (m_age >= LD ? 2'd2 : 2'd1);
            n_checks++;
            if (event_valid !== m_valid || (m_valid && event_code !== m_code) ||
                overflow !== m_ovf || state !== es) begin
                $display("FAIL model t=%0t got v=%b c=%b o=%b s=%b want v=%b c=%b o=%b s=%b",
                         $time, event_valid, event_code, overflow, state,
                         m_valid, m_code, m_ovf, es);
            end else begin
                n_pass++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed checking helpers
    // ------------------------------------------------------------------
    task automatic check(input string nm, input logic ev, input logic [1:0] ec,
                         input logic cc, input logic eo, input logic [1:0] es);
        n_checks++;
        if (event_valid !== ev || (cc && event_code !== ec) ||
            overflow !== eo || state !== es) begin
            $display("FAIL %s got v=%b c=%b o=%b s=%b want v=%b c=%b o=%b s=%b",
                     nm, event_valid, event_code, overflow, state, ev, ec, eo, es);
        end else begin
            n_pass++;
        end
    endtask

    // Apply inputs for one cycle (called just after a falling edge), then
    // check the outputs at the next falling edge.
    task automatic step(input string nm, input logic b, input logic r, input logic c,
                        input logic e, input logic ev, input logic [1:0] ec,
                        input logic eo, input logic [1:0] es);
        btn_level    = b;
        event_ready  = r;
        overflow_clr = c;
        enable       = e;
        @(posedge clk);
        @(negedge clk);
        check(nm, ev, ec, ev, eo, es);
    endtask

    typedef struct {
        logic       btn;
        logic       rdy;
        logic       clr;
        logic       en;
        logic       ev;
        logic [1:0] ec;
        logic       eo;
        logic [1:0] es;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic b, input logic r, input logic c, input logic e,
                       input logic ev, input logic [1:0] ec, input logic eo,
                       input logic [1:0] es);
        vec_t v;
        v.btn = b; v.rdy = r; v.clr = c; v.en = e;
        v.ev = ev; v.ec = ec; v.eo = eo; v.es = es;
        tbl.push_back(v);
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        model_chk    = 1'b0;
        reset        = 1'b1;
        enable       = 1'b1;
        btn_level    = 1'b0;
        event_ready  = 1'b1;
        overflow_clr = 1'b0;

        // Short press: 8 cycles high
        add(1, 1, 0, 1, 1, 2'b00, 0, 2'b01);
        for (int i = 0; i < 7; i++) add(1, 1, 0, 1, 0, 2'b00, 0, 2'b01);
        add(0, 1, 0, 1, 1, 2'b01, 0, 2'b00);
        add(0, 1, 0, 1, 0, 2'b00, 0, 2'b00);
        // Backpressure: PRESS held stable, RELEASE dropped, then drain and clear
        add(1, 0, 0, 1, 1, 2'b00, 0, 2'b01);
        add(1, 0, 0, 1, 1, 2'b00, 0, 2'b01);
        add(1, 0, 0, 1, 1, 2'b00, 0, 2'b01);
        add(0, 0, 0, 1, 1, 2'b00, 1, 2'b00);
        add(0, 0, 0, 1, 1, 2'b00, 1, 2'b00);
        add(0, 1, 0, 1, 0, 2'b00, 1, 2'b00);
        add(0, 1, 1, 1, 0, 2'b00, 0, 2'b00);
        add(0, 1, 0, 1, 0, 2'b00, 0, 2'b00);
        // Simultaneous consume and load
        add(1, 0, 0, 1, 1, 2'b00, 0, 2'b01);
        add(1, 0, 0, 1, 1, 2'b00, 0, 2'b01);
        add(0, 1, 0, 1, 1, 2'b01, 0, 2'b00);
        add(0, 1, 0, 1, 0, 2'b00, 0, 2'b00);
        // Drop and clear in the same cycle: set wins
        add(1, 0, 0, 1, 1, 2'b00, 0, 2'b01);
        add(0, 0, 1, 1, 1, 2'b00, 1, 2'b00);
        add(0, 1, 1, 1, 0, 2'b00, 0, 2'b00);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset_state", 1'b0, 2'b00, 1'b1, 1'b0, 2'b00);
        reset = 1'b0;

        foreach (tbl[i]) begin
            step($sformatf("vec%0d", i), tbl[i].btn, tbl[i].rdy, tbl[i].clr, tbl[i].en,
                 tbl[i].ev, tbl[i].ec, tbl[i].eo, tbl[i].es);
        end

        // Long hold: PRESS at 0, LONG at 12, REPEAT at 20 and 28, then RELEASE
        for (int k = 0; k < 30; k++) begin
            logic       ev;
            logic [1:0] ec;
            ev = (k == 0) || (k == 12) || (k == 20) || (k == 28);
            ec = (k == 0) ? 2'b00 : (k == 12) ? 2'b10 : 2'b11;
            step($sformatf("long_k%0d", k), 1, 1, 0, 1, ev, ec, 0, (k < 12) ? 2'b01 : 2'b10);
        end
        step("long_release", 0, 1, 0, 1, 1, 2'b01, 0, 2'b00);
        step("long_idle", 0, 1, 0, 1, 0, 2'b00, 0, 2'b00);

        // Fall on the same edge as the LONG tick: RELEASE only
        for (int k = 0; k < 12; k++) begin
            step($sformatf("fl_k%0d", k), 1, 1, 0, 1, (k == 0), 2'b00, 0, 2'b01);
        end
        step("fl_release", 0, 1, 0, 1, 1, 2'b01, 0, 2'b00);
        step("fl_idle", 0, 1, 0, 1, 0, 2'b00, 0, 2'b00);

        // Asynchronous reset in the middle of HELD
        for (int k = 0; k < 15; k++) begin
            logic       ev;
            ev = (k == 0) || (k == 12);
            step($sformatf("rh_k%0d", k), 1, 1, 0, 1, ev, (k == 0) ? 2'b00 : 2'b10, 0,
                 (k < 12) ? 2'b01 : 2'b10);
        end
        step("rh_drop", 0, 0, 0, 1, 1, 2'b01, 0, 2'b00);
        step("rh_press", 1, 0, 0, 1, 1, 2'b01, 1, 2'b01);
        #2 reset = 1'b1;
        #1 check("reset_async", 1'b0, 2'b00, 1'b1, 1'b0, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        // Button still high: first edge after reset sees a rise
        step("post_reset_press", 1, 1, 0, 1, 1, 2'b00, 0, 2'b01);
        for (int k = 0; k < 5; k++) begin
            step($sformatf("dis_k%0d", k), 1, 1, 0, 0, 0, 2'b00, 0, 2'b00);
        end
        for (int k = 0; k < 4; k++) begin
            step($sformatf("reen_k%0d", k), 1, 1, 0, 1, 0, 2'b00, 0, 2'b00);
        end
        step("reen_fall", 0, 1, 0, 1, 0, 2'b00, 0, 2'b00);
        step("reen_press", 1, 1, 0, 1, 1, 2'b00, 0, 2'b01);
        step("reen_hold", 1, 1, 0, 1, 0, 2'b00, 0, 2'b01);

        // Randomized phase against the reference model
        model_chk = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) btn_level = ~btn_level;
            event_ready  = ($urandom_range(0, 3) != 0);
            overflow_clr = ($urandom_range(0, 31) == 0);
            enable       = ($urandom_range(0, 63) != 0);
            @(posedge clk);
            @(negedge clk);
        end
        model_chk = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_event_ctrl.md
Name: button_event_ctrl

Overview:
Controller that sits after the per-button debounce stage and turns a debounced button level into discrete user events: PRESS, RELEASE, LONG (hold threshold reached) and REPEAT (auto-repeat while held). A prescaled time base and a 3-state FSM sequence the events. Events are delivered through a one-entry valid/ready slot to the command/UART logic, with a sticky overflow flag when the consumer stalls.

Parameters:
TICK_DIV, 200000, clk cycles per time-base tick (1 ms at 200 MHz); legal range 2..2^PRESC_WIDTH
PRESC_WIDTH, 18, prescaler counter width
LONG_TICKS, 1000, ticks from PRESS to LONG; legal range 1..2^TICK_WIDTH-1
REPEAT_TICKS, 200, ticks between REPEAT events while held; 0 disables repeat
TICK_WIDTH, 12, tick counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = controller active
btn_level  in  1  debounced button level, already synchronous to clk
event_ready  in  1  consumer accepts event
overflow_clr  in  1  single-cycle pulse, clears overflow
event_valid  out  1  event slot holds an event
event_code  out  2  00 PRESS, 01 RELEASE, 10 LONG, 11 REPEAT
overflow  out  1  sticky: an event was dropped
state  out  2  FSM state: 00 IDLE, 01 PRESSED, 10 HELD

Behaviour:
- Reset: the controller responds to clk and to an asynchronous, active-high reset. Reset forces state=IDLE, prescaler=0, tick counter=0, btn_prev=0, event_valid=0, event_code=00, overflow=0.
- btn_prev is registered from btn_level every cycle, regardless of enable.
  - rise = btn_level & ~btn_prev; fall = ~btn_level & btn_prev.
  - A button already high when reset releases gives a rise on the first clock edge.
- Prescaler: counts 0..TICK_DIV-1; tick = (prescaler == TICK_DIV-1), then wraps to 0. Prescaler and tick counter clear on every FSM state change.
- FSM, evaluated only when enable=1:
  - IDLE: on rise -> PRESSED, generate PRESS.
  - PRESSED: on fall -> IDLE, generate RELEASE. Else on tick with tick_cnt == LONG_TICKS-1 -> HELD, generate LONG. Else on tick, tick_cnt++.
  - HELD: on fall -> IDLE, generate RELEASE. Else if REPEAT_TICKS != 0, on tick with tick_cnt == REPEAT_TICKS-1 -> generate REPEAT, tick_cnt = 0, prescaler wraps normally. Else on tick, tick_cnt++.
  - Fall has priority over tick in the same cycle.
- enable=0:
  - FSM forced to IDLE; prescaler and tick counter held at 0; no events are generated.
  - A pending slot event is kept and can still be consumed.
  - A button held across the enable re-assertion produces no PRESS; a new rise is required.
- Latency: an edge on btn_level sampled at clock edge k gives event_valid=1 with the code after edge k (registered, 1 cycle).
- Event slot:
  - Transfer occurs when event_valid & event_ready.
  - event_code is stable while event_valid & ~event_ready.
  - New event with slot empty, or slot transferring in the same cycle: load it; event_valid stays/becomes 1.
  - New event while slot is full and not transferring: drop the new event, keep the old one, set overflow=1.
  - overflow clears only on overflow_clr or reset. If overflow_clr and a drop occur in the same cycle, set wins.
- Counter arithmetic is unsigned and wraps within its declared width. Parameters outside their legal range are unsupported.

Test Plan:
Test parameters: TICK_DIV=4, LONG_TICKS=3, REPEAT_TICKS=2, event_ready=1 unless stated otherwise.
- Short press: btn_level high for 8 cycles -> PRESS 1 cycle after rise, RELEASE 1 cycle after fall, no LONG, state returns to 00.
- Long hold: btn_level high for 30 cycles -> PRESS, LONG 12 cycles after the PRESS state entry, REPEAT 8 cycles later, a second REPEAT 8 cycles after that, then RELEASE, each as a 1-cycle event_valid pulse.
- Backpressure: ready=0, press then release 3 cycles later -> event_valid=1 with code 00 held stable, RELEASE dropped, overflow=1. Then ready=1 -> PRESS consumed. Then overflow_clr -> overflow=0.
- Simultaneous consume and load: ready=0 until RELEASE is generated, with ready=1 on that same cycle -> PRESS transfers, slot loads 01 with no gap, overflow stays 0.
- Fall coincides with LONG tick: release on the cycle the 3rd tick fires -> RELEASE only, no LONG, state=00.
- Reset/enable: assert reset mid-HELD -> all outputs 0 immediately (asynchronous). With the button held, drop enable for 5 cycles then restore it -> no events until a new rise.
